score_keeper: RTL and testbench
===============================

Name: score_keeper

Overview:
- Game-logic stage directly upstream of the score display block.
- Runs the round state machine (idle / running / game over) and converts game-frame ticks into a binary score.
- Also keeps the session high score and a speed level for the obstacle generator.
- Its score output drives the display block's score input on the same clk2 domain.

Parameters:
- SCORE_W, 13, width of score and high_score (holds up to 8191).
- MAX_SCORE, 6399, saturation value (maximum the 7-segment + dot-matrix display can show).
- TICKS_PER_POINT, 8, frame ticks per awarded point (must be >= 1).
- LEVEL_STEP, 100, points per speed-level increment (must be >= 1).

Ports:
- clk2  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- tick  input  1  game-frame strobe, one clk2 cycle wide.
- start  input  1  start/restart request, one-cycle pulse, already debounced.
- collision  input  1  dinosaur/obstacle hit, level or pulse.
- score  output  SCORE_W  current round score, binary.
- high_score  output  SCORE_W  best score since reset.
- speed_level  output  3  0..7, saturating.
- level_up  output  1  one-cycle pulse when speed_level increments.
- running  output  1  high in RUN state.
- game_over  output  1  high in OVER state.

Behaviour:
- Reset (reset low, asynchronous) clears all state and outputs:
  - state = IDLE.
  - score = 0, high_score = 0, speed_level = 0.
  - level_up = 0, running = 0, game_over = 0.
  - tick_cnt = 0, pts_cnt = 0.
- Outputs are registered, and the decoded flags are registered too. Every effect appears one cycle after the causing input is sampled.

State machine (state encoding is free):
- IDLE:
  - start -> RUN.
  - collision and tick are ignored.
- RUN:
  - collision -> OVER. Collision has priority over a tick in the same cycle: no point is awarded in that cycle.
  - start is ignored.
- OVER:
  - start -> RUN. On that transition, clear score, tick_cnt, pts_cnt and speed_level to 0; high_score is kept.
  - collision and tick are ignored.

Scoring (RUN only, no collision this cycle):
- Each tick increments tick_cnt.
- When tick arrives with tick_cnt == TICKS_PER_POINT-1: tick_cnt <= 0 and a point is awarded.
- Awarding a point: score <= score+1 if score < MAX_SCORE.
- At MAX_SCORE, score holds; tick_cnt keeps cycling, and pts_cnt and speed_level are frozen.

Speed level:
- On each awarded point below saturation, pts_cnt increments.
- When pts_cnt == LEVEL_STEP-1: pts_cnt <= 0, and if speed_level < 7 then speed_level <= speed_level+1 and level_up = 1 for exactly one cycle.
- At speed_level == 7: no further level_up, and pts_cnt keeps wrapping.

High score:
- On the RUN->OVER transition, high_score <= score if score > high_score.
- If score equals high_score, it is unchanged.

Timing and width rules:
- Ticks arriving on back-to-back cycles are each counted.
- All arithmetic is unsigned. score never exceeds MAX_SCORE.
- tick_cnt width is clog2(TICKS_PER_POINT)+1; pts_cnt width is clog2(LEVEL_STEP)+1.

Reset mid-operation:
- Any state returns to IDLE with all values cleared on the next evaluation.
- High score is lost on reset.

Test Plan:
1. Reset, then start pulse, then 16 ticks (TICKS_PER_POINT=8) -> running=1 one cycle after start; score=1 after 8th tick, score=2 after 16th; game_over=0.
2. In RUN with score=5, assert collision and tick in the same cycle -> state OVER, game_over=1, running=0, score stays 5, high_score=5.
3. From OVER with high_score=5, start, earn 3 points, collide -> score cleared to 0 on restart; after collision high_score stays 5. Then earn 7 points in the next round and collide -> high_score=7.
4. Parameters TICKS_PER_POINT=1, LEVEL_STEP=10; 80 continuous ticks -> level_up pulses exactly at scores 10,20,...,70 (7 pulses) and speed_level=7. Continue to score 90 -> no further pulses, speed_level stays 7.
5. Preload score near saturation by ticking with TICKS_PER_POINT=1 until 6399, then 5 more ticks -> score stays 6399, no level_up, no wrap to 0.
6. Assert reset low mid-RUN (asynchronously, between clk2 edges) with score=42, high_score=30 -> all outputs 0 immediately, including high_score. Ticks while in IDLE leave score at 0.

Source files
------------

// File: rtl/score_keeper.sv
// score_keeper: round FSM turning frame ticks into a saturating score, with high score and speed level.
module score_keeper #(
    parameter int SCORE_W         = 13,
    parameter int MAX_SCORE       = 6399,
    parameter int TICKS_PER_POINT = 8,
    parameter int LEVEL_STEP      = 100
) (
    input  logic               clk2,
    input  logic               reset,
    input  logic               tick,
    input  logic               start,
    input  logic               collision,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] high_score,
    output logic [2:0]         speed_level,
    output logic               level_up,
    output logic               running,
    output logic               game_over
);
    localparam int TW = $clog2(TICKS_PER_POINT) + 1;
    localparam int PW = $clog2(LEVEL_STEP) + 1;
    localparam logic [TW-1:0]      T_LAST = TW'(TICKS_PER_POINT - 1);
    localparam logic [PW-1:0]      P_LAST = PW'(LEVEL_STEP - 1);
    localparam logic [SCORE_W-1:0] S_MAX  = SCORE_W'(MAX_SCORE);

    typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

    state_t             state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d, high_q, high_d;
    logic [TW-1:0]      tick_q, tick_d;
    logic [PW-1:0]      pts_q, pts_d;
    logic [2:0]         level_q, level_d;
    logic               level_up_q, level_up_d, running_q, game_over_q;

    always_comb begin
        state_d    = state_q;
        score_d    = score_q;
        high_d     = high_q;
        tick_d     = tick_q;
        pts_d      = pts_q;
        level_d    = level_q;
        level_up_d = 1'b0;
        if (state_q != RUN) begin
            if (start) begin
                state_d = RUN;
                score_d = '0;
                tick_d  = '0;
                pts_d   = '0;
                level_d = '0;
            end
        end else if (collision) begin
            state_d = OVER;
            high_d  = (score_q > high_q) ? score_q : high_q;
        end else if (tick) begin
            tick_d = (tick_q == T_LAST) ? '0 : tick_q + 1'b1;
            // pts_cnt and level freeze once the score saturates
            if (tick_q == T_LAST && score_q < S_MAX) begin
                score_d = score_q + 1'b1;
                pts_d   = (pts_q == P_LAST) ? '0 : pts_q + 1'b1;
                if (pts_q == P_LAST && level_q != 3'd7) begin
                    level_d    = level_q + 1'b1;
                    level_up_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk2 or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            score_q     <= '0;
            high_q      <= '0;
            tick_q      <= '0;
            pts_q       <= '0;
            level_q     <= '0;
            level_up_q  <= 1'b0;
            running_q   <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            score_q     <= score_d;
            high_q      <= high_d;
            tick_q      <= tick_d;
            pts_q       <= pts_d;
            level_q     <= level_d;
            level_up_q  <= level_up_d;
            running_q   <= (state_d == RUN);
            game_over_q <= (state_d == OVER);
        end
    end

    assign score       = score_q;
    assign high_score  = high_q;
    assign speed_level = level_q;
    assign level_up    = level_up_q;
    assign running     = running_q;
    assign game_over   = game_over_q;
endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: vector table on a default instance plus level/saturation/reset sequences on a fast instance.
module tb_score_keeper;
    logic        clk2 = 1'b0;
    logic        reset = 1'b0;
    logic        a_tick = 0, a_start = 0, a_col = 0;
    logic        b_tick = 0, b_start = 0, b_col = 0;
    logic [12:0] a_score, a_high, b_score, b_high;
    logic [2:0]  a_level, b_level;
    logic        a_lu, a_run, a_over, b_lu, b_run, b_over;
    int          total = 0, bad = 0;

    always #5 clk2 = ~clk2;

    score_keeper dut_a (
        .clk2(clk2), .reset(reset), .tick(a_tick), .start(a_start), .collision(a_col),
        .score(a_score), .high_score(a_high), .speed_level(a_level),
        .level_up(a_lu), .running(a_run), .game_over(a_over)
    );

    score_keeper #(.SCORE_W(13), .MAX_SCORE(6399), .TICKS_PER_POINT(1), .LEVEL_STEP(10)) dut_b (
        .clk2(clk2), .reset(reset), .tick(b_tick), .start(b_start), .collision(b_col),
        .score(b_score), .high_score(b_high), .speed_level(b_level),
        .level_up(b_lu), .running(b_run), .game_over(b_over)
    );

    typedef struct {
        int   n;
        logic st, col, tk;
        int   score, high, run, over;
    } vec_t;
    vec_t vq[$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic b_cycle(input logic st, input logic col, input logic tk);
        @(negedge clk2);
        b_start = st; b_col = col; b_tick = tk;
        @(posedge clk2);
        #1;
    endtask

    initial begin
        // n, start, collision, tick, score, high, running, game_over
        vq.push_back('{1,  0, 0, 0, 0, 0, 0, 0});
        vq.push_back('{3,  0, 0, 1, 0, 0, 0, 0});
        vq.push_back('{1,  0, 1, 0, 0, 0, 0, 0});
        vq.push_back('{1,  1, 0, 0, 0, 0, 1, 0});
        vq.push_back('{7,  0, 0, 1, 0, 0, 1, 0});
        vq.push_back('{1,  0, 0, 1, 1, 0, 1, 0});
        vq.push_back('{8,  0, 0, 1, 2, 0, 1, 0});
        vq.push_back('{24, 0, 0, 1, 5, 0, 1, 0});
        vq.push_back('{1,  1, 0, 0, 5, 0, 1, 0});
        vq.push_back('{7,  0, 0, 1, 5, 0, 1, 0});
        vq.push_back('{1,  0, 1, 1, 5, 5, 0, 1});
        vq.push_back('{3,  0, 0, 1, 5, 5, 0, 1});
        vq.push_back('{1,  1, 0, 0, 0, 5, 1, 0});
        vq.push_back('{7,  0, 0, 1, 0, 5, 1, 0});
        vq.push_back('{1,  0, 0, 1, 1, 5, 1, 0});
        vq.push_back('{16, 0, 0, 1, 3, 5, 1, 0});
        vq.push_back('{1,  0, 1, 0, 3, 5, 0, 1});
        vq.push_back('{1,  1, 0, 0, 0, 5, 1, 0});
        vq.push_back('{56, 0, 0, 1, 7, 5, 1, 0});
        vq.push_back('{1,  0, 1, 0, 7, 7, 0, 1});
        vq.push_back('{1,  1, 1, 0, 0, 7, 1, 0});
        vq.push_back('{1,  0, 1, 0, 0, 7, 0, 1});

        #12 reset = 1'b1;
        chk("a_reset_score", a_score, 0);
        chk("a_reset_run", a_run, 0);

        foreach (vq[i]) begin
            for (int k = 0; k < vq[i].n; k++) begin
                @(negedge clk2);
                a_start = vq[i].st; a_col = vq[i].col; a_tick = vq[i].tk;
                @(posedge clk2);
                #1;
            end
            chk($sformatf("v%0d_score", i), a_score, vq[i].score);
            chk($sformatf("v%0d_high", i), a_high, vq[i].high);
            chk($sformatf("v%0d_run", i), a_run, vq[i].run);
            chk($sformatf("v%0d_over", i), a_over, vq[i].over);
            chk($sformatf("v%0d_level", i), a_level, 0);
            chk($sformatf("v%0d_lu", i), a_lu, 0);
        end
        @(negedge clk2);
        a_start = 0; a_col = 0; a_tick = 0;

        // level pulses at 10..70, none beyond
        b_cycle(1, 0, 0);
        chk("b_run", b_run, 1);
        for (int i = 1; i <= 90; i++) begin
            b_cycle(0, 0, 1);
            chk($sformatf("b_score_%0d", i), b_score, i);
            chk($sformatf("b_lu_%0d", i), b_lu, (i % 10 == 0 && i <= 70) ? 1 : 0);
            chk($sformatf("b_level_%0d", i), b_level, (i / 10 > 7) ? 7 : i / 10);
        end
        for (int i = 91; i <= 6399; i++) b_cycle(0, 0, 1);
        chk("b_sat_score", b_score, 6399);
        chk("b_sat_level", b_level, 7);
        for (int i = 0; i < 5; i++) begin
            b_cycle(0, 0, 1);
            chk($sformatf("b_hold_score_%0d", i), b_score, 6399);
            chk($sformatf("b_hold_lu_%0d", i), b_lu, 0);
        end
        b_cycle(0, 1, 0);
        chk("b_sat_high", b_high, 6399);

        // fresh session: high 30, then score 42 when reset hits
        @(negedge clk2);
        reset = 1'b0;
        #2 reset = 1'b1;
        b_cycle(1, 0, 0);
        for (int i = 0; i < 30; i++) b_cycle(0, 0, 1);
        chk("b_s30", b_score, 30);
        chk("b_l3", b_level, 3);
        b_cycle(0, 1, 0);
        chk("b_h30", b_high, 30);
        b_cycle(1, 0, 0);
        chk("b_restart_score", b_score, 0);
        chk("b_restart_level", b_level, 0);
        for (int i = 0; i < 42; i++) b_cycle(0, 0, 1);
        chk("b_s42", b_score, 42);
        chk("b_h30_kept", b_high, 30);
        chk("b_l4", b_level, 4);
        #2 reset = 1'b0;
        #1;
        chk("rst_b_score", b_score, 0);
        chk("rst_b_high", b_high, 0);
        chk("rst_b_level", b_level, 0);
        chk("rst_b_run", b_run, 0);
        chk("rst_b_over", b_over, 0);
        chk("rst_b_lu", b_lu, 0);
        chk("rst_a_high", a_high, 0);
        chk("rst_a_over", a_over, 0);
        @(negedge clk2);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) b_cycle(0, 0, 1);
        chk("idle_b_score", b_score, 0);
        chk("idle_b_run", b_run, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
